// File: rtl/inst_issue_fifo.sv
// Dual-ported instruction FIFO between fetch and the dual-issue decode slots.
// Accepts 0/1/2 pushes and 0/1/2 pops per cycle with first-word-fall-through heads.
module inst_issue_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push_master,
  input  logic                     push_slave,
  input  logic [DATA_W-1:0]        push_data_master,
  input  logic [DATA_W-1:0]        push_data_slave,
  input  logic                     pop_master,
  input  logic                     pop_slave,
  output logic [DATA_W-1:0]        head_data_master,
  output logic [DATA_W-1:0]        head_data_slave,
  output logic                     head_valid_master,
  output logic                     head_valid_slave,
  output logic                     fifo_empty,
  output logic                     fifo_almost_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_pm;
  logic              w_ps;
  logic              w_qm;
  logic              w_qs;
  logic [1:0]        w_push_n;
  logic [1:0]        w_pop_n;
  logic [PTR_W-1:0]  w_wr_ptr1;
  logic [PTR_W-1:0]  w_rd_ptr1;

  // Status decoded from the registered occupancy
  assign count             = r_count;
  assign fifo_empty        = (r_count == CNT_W'(0));
  assign fifo_almost_empty = (r_count == CNT_W'(1));
  assign fifo_full         = (r_count >= CNT_W'(DEPTH - 1));
  assign head_valid_master = (r_count >= CNT_W'(1));
  assign head_valid_slave  = (r_count >= CNT_W'(2));

  // Effective requests; slave lanes only ride along with their master lane
  assign w_pm     = push_master & ~fifo_full & ~flush;
  assign w_ps     = w_pm & push_slave;
  assign w_qm     = pop_master & head_valid_master & ~flush;
  assign w_qs     = w_qm & pop_slave & head_valid_slave;
  assign w_push_n = {1'b0, w_pm} + {1'b0, w_ps};
  assign w_pop_n  = {1'b0, w_qm} + {1'b0, w_qs};

  assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr1 = r_rd_ptr + PTR_W'(1);

  assign head_data_master = head_valid_master ? r_mem[r_rd_ptr]  : '0;
  assign head_data_slave  = head_valid_slave  ? r_mem[w_rd_ptr1] : '0;

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (w_pm) r_mem[r_wr_ptr]  <= push_data_master;
    if (w_ps) r_mem[w_wr_ptr1] <= push_data_slave;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
      r_count  <= r_count + CNT_W'(w_push_n) - CNT_W'(w_pop_n);
    end
  end

endmodule

// File: tb/tb_inst_issue_fifo.sv
// Directed self-checking bench for inst_issue_fifo (DEPTH=16, DATA_W=64).
module tb_inst_issue_fifo;

  logic        clk = 1'b0;
  logic        rst_n, flush, push_master, push_slave, pop_master, pop_slave;
  logic [63:0] push_data_master, push_data_slave;
  logic [63:0] head_data_master, head_data_slave;
  logic        head_valid_master, head_valid_slave;
  logic        fifo_empty, fifo_almost_empty, fifo_full;
  logic [4:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  inst_issue_fifo #(.DEPTH(16), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_master(push_master), .push_slave(push_slave),
    .push_data_master(push_data_master), .push_data_slave(push_data_slave),
    .pop_master(pop_master), .pop_slave(pop_slave),
    .head_data_master(head_data_master), .head_data_slave(head_data_slave),
    .head_valid_master(head_valid_master), .head_valid_slave(head_valid_slave),
    .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
    .fifo_full(fifo_full), .count(count)
  );

  always #5 clk = ~clk;

  // Entry k: sequential pc with a tagged instruction word
  function automatic logic [63:0] ent(input int k);
    return {32'h0000_1000 + 32'(k * 4), 32'hA000_0000 + 32'(k)};
  endfunction

  // Apply one cycle of stimulus, then sample #1 after the edge
  task automatic cyc(input logic pm, input logic ps, input logic [63:0] dm,
                     input logic [63:0] ds, input logic qm, input logic qs,
                     input logic fl, input logic rn);
    push_master = pm; push_slave = ps; push_data_master = dm; push_data_slave = ds;
    pop_master = qm; pop_slave = qs; flush = fl; rst_n = rn;
    @(posedge clk); #1;
    push_master = 0; push_slave = 0; pop_master = 0; pop_slave = 0; flush = 0; rst_n = 1;
  endtask

  task automatic do_reset();
    cyc(0, 0, '0, '0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if ({fifo_empty, fifo_almost_empty, fifo_full} !== 3'b100) begin n_fail++; $display("FAIL reset_status got %b exp 100", {fifo_empty, fifo_almost_empty, fifo_full}); end
    n_tests++; if ({head_valid_master, head_valid_slave} !== 2'b00) begin n_fail++; $display("FAIL reset_valid got %b exp 00", {head_valid_master, head_valid_slave}); end
    n_tests++; if (head_data_master !== 64'd0) begin n_fail++; $display("FAIL reset_hdm got %h exp 0", head_data_master); end
  endtask

  task automatic test_push_pair();
    cyc(1, 1, ent(0), ent(1), 0, 0, 0, 1);
    n_tests++; if (count !== 5'd2) begin n_fail++; $display("FAIL pair_count got %0d exp 2", count); end
    n_tests++; if (head_data_master !== ent(0)) begin n_fail++; $display("FAIL pair_hdm got %h exp %h", head_data_master, ent(0)); end
    n_tests++; if (head_data_slave !== ent(1)) begin n_fail++; $display("FAIL pair_hds got %h exp %h", head_data_slave, ent(1)); end
    n_tests++; if ({fifo_empty, fifo_almost_empty} !== 2'b00) begin n_fail++; $display("FAIL pair_status got %b exp 00", {fifo_empty, fifo_almost_empty}); end
  endtask

  task automatic test_pop_master();
    cyc(0, 0, '0, '0, 1, 0, 0, 1);
    n_tests++; if (count !== 5'd1) begin n_fail++; $display("FAIL popm_count got %0d exp 1", count); end
    n_tests++; if (head_data_master !== ent(1)) begin n_fail++; $display("FAIL popm_hdm got %h exp %h", head_data_master, ent(1)); end
    n_tests++; if (fifo_almost_empty !== 1'b1) begin n_fail++; $display("FAIL popm_ae got %b exp 1", fifo_almost_empty); end
    n_tests++; if (head_valid_slave !== 1'b0) begin n_fail++; $display("FAIL popm_hvs got %b exp 0", head_valid_slave); end
    n_tests++; if (head_data_slave !== 64'd0) begin n_fail++; $display("FAIL popm_hds got %h exp 0", head_data_slave); end
  endtask

  task automatic test_underflow();
    cyc(0, 0, '0, '0, 1, 1, 0, 1);
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL uflow_count got %0d exp 0", count); end
    n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL uflow_empty got %b exp 1", fifo_empty); end
    cyc(0, 0, '0, '0, 1, 1, 0, 1);
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL uflow_empty_pop got %0d exp 0", count); end
  endtask

  task automatic test_ignored();
    do_reset();
    cyc(0, 1, ent(7), ent(8), 0, 0, 0, 1);
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL slave_only_push got %0d exp 0", count); end
    cyc(1, 1, ent(0), ent(1), 0, 0, 0, 1);
    cyc(0, 0, '0, '0, 0, 1, 0, 1);
    n_tests++; if (count !== 5'd2) begin n_fail++; $display("FAIL slave_only_pop got %0d exp 2", count); end
    cyc(1, 1, ent(2), ent(3), 0, 0, 0, 1);
    n_tests++; if (head_data_master !== ent(0) || count !== 5'd4) begin n_fail++; $display("FAIL fwft_latency got %h/%0d exp %h/4", head_data_master, count, ent(0)); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, 1, ent(2*i), ent(2*i+1), 0, 0, 0, 1);
    n_tests++; if (count !== 5'd14 || fifo_full !== 1'b0) begin n_fail++; $display("FAIL fill14 got %0d/%b exp 14/0", count, fifo_full); end
    cyc(1, 0, ent(14), '0, 0, 0, 0, 1);
    n_tests++; if (count !== 5'd15 || fifo_full !== 1'b1) begin n_fail++; $display("FAIL fill15 got %0d/%b exp 15/1", count, fifo_full); end
    cyc(1, 1, ent(99), ent(99), 0, 0, 0, 1);
    cyc(1, 1, ent(99), ent(99), 0, 0, 0, 1);
    n_tests++; if (count !== 5'd15) begin n_fail++; $display("FAIL full_drop got %0d exp 15", count); end
    cyc(1, 1, ent(99), ent(99), 1, 0, 0, 1);
    n_tests++; if (count !== 5'd14) begin n_fail++; $display("FAIL full_pop_drop got %0d exp 14", count); end
    cyc(1, 1, ent(15), ent(16), 0, 0, 0, 1);
    n_tests++; if (count !== 5'd16 || fifo_full !== 1'b1) begin n_fail++; $display("FAIL fill16 got %0d/%b exp 16/1", count, fifo_full); end
    cyc(1, 1, ent(99), ent(99), 0, 0, 0, 1);
    n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL no_overflow got %0d exp 16", count); end
    n_tests++; if (head_data_master !== ent(1) || head_data_slave !== ent(2)) begin n_fail++; $display("FAIL full_heads got %h %h exp %h %h", head_data_master, head_data_slave, ent(1), ent(2)); end
  endtask

  task automatic test_back_to_back();
    int wr_k = 4;
    int rd_k = 0;
    do_reset();
    cyc(1, 1, ent(0), ent(1), 0, 0, 0, 1);
    cyc(1, 1, ent(2), ent(3), 0, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      n_tests++; if (head_data_master !== ent(rd_k) || head_data_slave !== ent(rd_k+1)) begin n_fail++; $display("FAIL b2b_order it %0d got %h %h exp %h %h", i, head_data_master, head_data_slave, ent(rd_k), ent(rd_k+1)); end
      cyc(1, 1, ent(wr_k), ent(wr_k+1), 1, 1, 0, 1);
      wr_k += 2; rd_k += 2;
      n_tests++; if (count !== 5'd4) begin n_fail++; $display("FAIL b2b_count it %0d got %0d exp 4", i, count); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    cyc(1, 1, ent(0), ent(1), 0, 0, 0, 1);
    cyc(1, 0, ent(2), '0, 0, 0, 0, 1);
    n_tests++; if (count !== 5'd3) begin n_fail++; $display("FAIL flush_pre got %0d exp 3", count); end
    cyc(1, 1, ent(3), ent(4), 1, 1, 1, 1);
    n_tests++; if (count !== 5'd0 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL flush_clear got %0d/%b exp 0/1", count, fifo_empty); end
    cyc(1, 0, ent(20), '0, 0, 0, 0, 1);
    n_tests++; if (count !== 5'd1 || head_data_master !== ent(20)) begin n_fail++; $display("FAIL flush_after got %0d/%h exp 1/%h", count, head_data_master, ent(20)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, ent(2*i), ent(2*i+1), 0, 0, 0, 1);
    cyc(1, 0, ent(8), '0, 0, 0, 0, 1);
    n_tests++; if (count !== 5'd9) begin n_fail++; $display("FAIL mid_pre got %0d exp 9", count); end
    cyc(1, 1, ent(30), ent(31), 1, 0, 1, 0);
    n_tests++; if (count !== 5'd0 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL mid_reset got %0d/%b exp 0/1", count, fifo_empty); end
    cyc(1, 0, ent(50), '0, 0, 0, 0, 1);
    n_tests++; if (head_data_master !== ent(50) || count !== 5'd1) begin n_fail++; $display("FAIL mid_first got %h/%0d exp %h/1", head_data_master, count, ent(50)); end
  endtask

  initial begin
    rst_n = 0; flush = 0; push_master = 0; push_slave = 0; pop_master = 0; pop_slave = 0;
    push_data_master = '0; push_data_slave = '0;
    test_reset();
    test_push_pair();
    test_pop_master();
    test_underflow();
    test_ignored();
    test_fill();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
